present_out_buffer: RTL and testbench



---
 rtl/present_pkg.sv | 18 +
 rtl/present_out_buffer_if.sv | 27 ++
 rtl/present_key_update.sv | 20 ++
 rtl/present_out_buffer.sv | 118 +++++++++++
 tb/tb_present_out_buffer.sv | 182 ++++++++++++++++++
 5 files changed

// File: rtl/present_pkg.sv
// rtl/present_pkg.sv - PRESENT-80 shared constants, S-box table and lookup helper
package present_pkg;

  localparam int STATE_W = 64;
  localparam int KEY_W   = 80;
  localparam int RC_W    = 5;

  // PRESENT 4-bit S-box, indexed by the input nibble.
  localparam logic [3:0] SBOX [16] = '{
    4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
    4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2
  };

  function automatic logic [3:0] sbox4(input logic [3:0] x);
    return SBOX[x];
  endfunction

endpackage

// File: rtl/present_out_buffer_if.sv
// rtl/present_out_buffer_if.sv - round-31 input and ciphertext stream bundle
interface present_out_buffer_if;
  import present_pkg::*;

  // producer side: last round stage, no backpressure
  logic               in_valid;
  logic [STATE_W-1:0] state_in;
  logic [KEY_W-1:0]   key_in;

  // consumer side: ready/valid ciphertext stream
  logic               out_valid;
  logic               out_ready;
  logic [STATE_W-1:0] out_data;

  // environment driving the buffer
  modport master (
    output in_valid, state_in, key_in, out_ready,
    input  out_valid, out_data
  );

  // the buffer itself
  modport slave (
    input  in_valid, state_in, key_in, out_ready,
    output out_valid, out_data
  );

endinterface

// File: rtl/present_key_update.sv
// rtl/present_key_update.sv - one PRESENT-80 key-schedule step (combinational)
module present_key_update
  import present_pkg::*;
(
  input  logic [KEY_W-1:0] key,
  input  logic [RC_W-1:0]  rc,
  output logic [KEY_W-1:0] key_next
);

  logic [KEY_W-1:0] rot;

  // rotate left by 61, substitute the top nibble, fold the round counter in
  always_comb begin
    rot             = {key[18:0], key[79:19]};
    key_next        = rot;
    key_next[79:76] = sbox4(rot[79:76]);
    key_next[19:15] = rot[19:15] ^ rc;
  end

endmodule

// File: rtl/present_out_buffer.sv
// rtl/present_out_buffer.sv - final whitening stage plus ciphertext output FIFO
module present_out_buffer
  import present_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  present_out_buffer_if.slave        bus,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       overflow,
  input  logic                       clr_ovf
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);
  localparam logic [RC_W-1:0]  LAST_RC  = RC_W'(31);

  logic [KEY_W-1:0]   k32;
  logic               unused_key_bits;

  logic [STATE_W-1:0] ct_d, ct_q;
  logic               ct_v_d, ct_v_q;
  logic [STATE_W-1:0] mem_d [DEPTH];
  logic [STATE_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_d, wr_ptr_q;
  logic [PTR_W-1:0]   rd_ptr_d, rd_ptr_q;
  logic [LVL_W-1:0]   level_d, level_q;
  logic               ovf_d, ovf_q;

  logic               full;
  logic               pop;
  logic               push;
  logic               drop;

  present_key_update u_key_update (
    .key      (bus.key_in),
    .rc       (LAST_RC),
    .key_next (k32)
  );

  // only the upper 64 bits of the final round key whiten the state
  assign unused_key_bits = ^k32[15:0];

  // final key whitening; the stage register captures every cycle, no stall
  always_comb begin
    ct_d   = bus.state_in ^ k32[79:16];
    ct_v_d = bus.in_valid;
  end

  // FIFO control: push unless full without a simultaneous pop, otherwise drop
  always_comb begin
    full     = (level_q == LVL_FULL);
    pop      = (level_q != '0) && bus.out_ready;
    push     = ct_v_q && (!full || pop);
    drop     = ct_v_q && full && !pop;

    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;

    if (push) begin
      mem_d[wr_ptr_q] = ct_q;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end

    case ({push, pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  // sticky overflow flag; a drop in the same cycle wins over the clear
  always_comb begin
    ovf_d = ovf_q;
    if (drop) begin
      ovf_d = 1'b1;
    end else if (clr_ovf) begin
      ovf_d = 1'b0;
    end
  end

  // state registers; reset discards stored entries and any in-flight ciphertext
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ct_q     <= '0;
      ct_v_q   <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      ct_q     <= ct_d;
      ct_v_q   <= ct_v_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      ovf_q    <= ovf_d;
      mem_q    <= mem_d;
    end
  end

  // outputs come straight from registers, nothing combinational from out_ready
  assign bus.out_valid = (level_q != '0);
  assign bus.out_data  = mem_q[rd_ptr_q];
  assign level         = level_q;
  assign overflow      = ovf_q;

endmodule

// File: tb/tb_present_out_buffer.sv
// tb/tb_present_out_buffer.sv - directed self-checking bench for present_out_buffer
module tb_present_out_buffer;
  import present_pkg::*;

  localparam int DEPTH = 4;
  localparam logic [63:0] CT0 = 64'hC000_0000_0000_000F;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clr_ovf = 1'b0;
  logic [2:0] level;
  logic       overflow;

  int n_checks = 0;
  int n_fail   = 0;

  present_out_buffer_if bus ();

  present_out_buffer #(.DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .level    (level),
    .overflow (overflow),
    .clr_ovf  (clr_ovf)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // one vector into an empty FIFO: two-cycle latency, then popped
  task automatic single(input string tag, input logic [79:0] key,
                        input logic [63:0] state, input logic [63:0] exp);
    bus.key_in   = key;
    bus.state_in = state;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    chk({tag, "_valid_n1"}, bus.out_valid, 0);
    tick();
    chk({tag, "_valid_n2"}, bus.out_valid, 1);
    chk({tag, "_data"}, bus.out_data, exp);
    chk({tag, "_level"}, level, 1);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk({tag, "_level_pop"}, level, 0);
    chk({tag, "_valid_pop"}, bus.out_valid, 0);
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.state_in  = '0;
    bus.key_in    = '0;
    bus.out_ready = 1'b0;

    // reset state
    #12;
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_level", level, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_data", bus.out_data, 0);
    rst_n = 1'b1;
    tick();

    // single vectors
    single("zero", 80'h0, 64'h0, CT0);
    single("ones_state", 80'h0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h3FFF_FFFF_FFFF_FFF0);
    single("ones_key", {80{1'b1}}, 64'h0, 64'h2FFF_FFFF_FFFF_FFF0);
    single("key_bit0", 80'h1, 64'h0, 64'hC000_2000_0000_000F);

    // back-to-back with the consumer always ready
    bus.key_in    = '0;
    bus.out_ready = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      bus.in_valid = (k <= 8);
      bus.state_in = 64'(k);
      tick();
      chk("b2b_valid", bus.out_valid, 64'(k >= 2 && k <= 9));
      if (k >= 2 && k <= 9) chk("b2b_data", bus.out_data, 64'(k - 1) ^ CT0);
      chk("b2b_level_le1", 64'(level <= 3'd1), 1);
    end
    chk("b2b_ovf", overflow, 0);
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b0;

    // overflow: six writes into a stalled FIFO; clear collides with the first drop
    for (int j = 0; j < 6; j++) begin
      bus.in_valid = 1'b1;
      bus.state_in = 64'h100 + 64'(j);
      clr_ovf      = (j == 5);
      tick();
      if (j == 4) begin
        chk("ovf_level_full", level, 4);
        chk("ovf_not_yet", overflow, 0);
      end
      if (j == 5) begin
        chk("ovf_set_beats_clr", overflow, 1);
        chk("ovf_level_held", level, 4);
      end
    end
    clr_ovf      = 1'b0;
    bus.in_valid = 1'b0;
    tick();
    chk("ovf_level_after6", level, 4);
    chk("ovf_sticky", overflow, 1);
    bus.out_ready = 1'b1;
    for (int j = 0; j < 4; j++) begin
      chk("ovf_drain_valid", bus.out_valid, 1);
      chk("ovf_drain_data", bus.out_data, (64'h100 + 64'(j)) ^ CT0);
      tick();
    end
    bus.out_ready = 1'b0;
    chk("ovf_drain_empty", bus.out_valid, 0);
    chk("ovf_drain_level", level, 0);
    chk("ovf_still_set", overflow, 1);
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    chk("ovf_cleared", overflow, 0);

    // full FIFO with simultaneous push and pop
    for (int j = 0; j < 4; j++) begin
      bus.in_valid = 1'b1;
      bus.state_in = 64'h200 + 64'(j);
      tick();
    end
    bus.in_valid = 1'b0;
    tick();
    chk("full_level", level, 4);
    bus.in_valid = 1'b1;
    bus.state_in = 64'h204;
    tick();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    chk("full_head", bus.out_data, 64'h200 ^ CT0);
    tick();
    chk("full_pushpop_level", level, 4);
    chk("full_pushpop_ovf", overflow, 0);
    for (int j = 1; j <= 4; j++) begin
      chk("full_order", bus.out_data, (64'h200 + 64'(j)) ^ CT0);
      tick();
    end
    bus.out_ready = 1'b0;
    chk("full_drained", level, 0);

    // asynchronous reset in the middle of a burst
    for (int j = 0; j < 4; j++) begin
      bus.in_valid = 1'b1;
      bus.state_in = 64'h300 + 64'(j);
      tick();
    end
    bus.in_valid = 1'b0;
    chk("mid_level3", level, 3);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", bus.out_valid, 0);
    chk("async_rst_level", level, 0);
    chk("async_rst_ovf", overflow, 0);
    #2 rst_n = 1'b1;
    tick();
    chk("post_rst_inflight_lost", level, 0);
    chk("post_rst_valid", bus.out_valid, 0);
    single("post_rst", 80'h0, 64'h0, CT0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
